// File: rtl/clk_gate_seq_ctrl.sv
// rtl/clk_gate_seq_ctrl.sv - per-channel clock-gate sequencer with idle-qualified drain and settle-on-wake
// Each channel runs ON -> DRAIN -> OFF -> WAKE independently; gate enables are registered from next-state.
module clk_gate_seq_ctrl #(
  parameter int NUM_CH    = 17,
  parameter int IDLE_HOLD = 4,
  parameter int WAKE_CYC  = 2,
  parameter int DRAIN_TO  = 255,
  parameter int CNT_W     = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [NUM_CH-1:0] sw_clk_en,
  input  logic [NUM_CH-1:0] wake_req,
  input  logic [NUM_CH-1:0] periph_idle,
  input  logic [NUM_CH-1:0] to_clr,
  output logic [31:0]       clk_gating_cfg,
  output logic [NUM_CH-1:0] clk_on_status,
  output logic [NUM_CH-1:0] to_flag,
  output logic              to_irq
);

  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] L_HOLD_LAST  = CNT_W'(IDLE_HOLD - 1);
  localparam logic [CNT_W-1:0] L_DRAIN_LAST = CNT_W'(DRAIN_TO - 1);
  localparam logic [CNT_W-1:0] L_WAKE_LAST  = CNT_W'(WAKE_CYC - 1);

  state_t             r_state [NUM_CH];
  logic [CNT_W-1:0]   r_cnt   [NUM_CH];
  logic [CNT_W-1:0]   r_hold  [NUM_CH];
  logic [NUM_CH-1:0]  r_cfg;
  logic [NUM_CH-1:0]  r_status;
  logic [NUM_CH-1:0]  r_to;

  state_t             w_nxt      [NUM_CH];
  logic [CNT_W-1:0]   w_cnt_nxt  [NUM_CH];
  logic [CNT_W-1:0]   w_hold_nxt [NUM_CH];
  logic [NUM_CH-1:0]  w_to_set;
  logic [NUM_CH-1:0]  w_want;
  logic [31:0]        w_cfg32;

  assign w_want = sw_clk_en | wake_req;

  always_comb begin
    w_to_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_nxt[i]      = r_state[i];
      w_cnt_nxt[i]  = r_cnt[i];
      w_hold_nxt[i] = r_hold[i];
      case (r_state[i])
        ST_ON: begin
          if (!w_want[i]) begin
            w_nxt[i]      = ST_DRAIN;
            w_cnt_nxt[i]  = '0;
            w_hold_nxt[i] = '0;
          end
        end
        ST_DRAIN: begin
          // Abort beats gating beats timeout; the idle run restarts but the timeout does not.
          if (w_want[i]) begin
            w_nxt[i] = ST_ON;
          end else if (periph_idle[i] && (r_hold[i] == L_HOLD_LAST)) begin
            w_nxt[i] = ST_OFF;
          end else if (r_cnt[i] == L_DRAIN_LAST) begin
            w_nxt[i]    = ST_ON;
            w_to_set[i] = 1'b1;
          end else begin
            w_cnt_nxt[i]  = r_cnt[i] + 1'b1;
            w_hold_nxt[i] = periph_idle[i] ? r_hold[i] + 1'b1 : '0;
          end
        end
        ST_OFF: begin
          if (w_want[i]) begin
            w_nxt[i]     = ST_WAKE;
            w_cnt_nxt[i] = '0;
          end
        end
        ST_WAKE: begin
          if (r_cnt[i] == L_WAKE_LAST) begin
            w_nxt[i] = ST_ON;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
          end
        end
        default: w_nxt[i] = ST_ON;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_ON;
        r_cnt[i]   <= '0;
        r_hold[i]  <= '0;
      end
      r_cfg    <= '1;
      r_status <= '1;
      r_to     <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]  <= w_nxt[i];
        r_cnt[i]    <= w_cnt_nxt[i];
        r_hold[i]   <= w_hold_nxt[i];
        r_cfg[i]    <= (w_nxt[i] != ST_OFF);
        r_status[i] <= (w_nxt[i] == ST_ON) || (w_nxt[i] == ST_DRAIN);
      end
      // A timeout landing on the same edge as a clear keeps the flag set.
      r_to <= (r_to & ~to_clr) | w_to_set;
    end
  end

  always_comb begin
    w_cfg32             = '0;
    w_cfg32[NUM_CH-1:0] = r_cfg;
  end

  assign clk_gating_cfg = w_cfg32;
  assign clk_on_status  = r_status;
  assign to_flag        = r_to;
  assign to_irq         = |r_to;

endmodule

// File: tb/tb_clk_gate_seq_ctrl.sv
// tb/tb_clk_gate_seq_ctrl.sv - directed self-checking bench for clk_gate_seq_ctrl
module tb_clk_gate_seq_ctrl;

  localparam int NUM_CH = 17;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [NUM_CH-1:0] sw_clk_en;
  logic [NUM_CH-1:0] wake_req;
  logic [NUM_CH-1:0] periph_idle;
  logic [NUM_CH-1:0] to_clr;
  logic [31:0]       clk_gating_cfg;
  logic [NUM_CH-1:0] clk_on_status;
  logic [NUM_CH-1:0] to_flag;
  logic              to_irq;

  int n_total = 0;
  int n_bad   = 0;

  clk_gate_seq_ctrl #(
    .NUM_CH(NUM_CH), .IDLE_HOLD(4), .WAKE_CYC(2), .DRAIN_TO(255), .CNT_W(8)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .sw_clk_en     (sw_clk_en),
    .wake_req      (wake_req),
    .periph_idle   (periph_idle),
    .to_clr        (to_clr),
    .clk_gating_cfg(clk_gating_cfg),
    .clk_on_status (clk_on_status),
    .to_flag       (to_flag),
    .to_irq        (to_irq)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] cfg, input logic [31:0] st,
                           input logic [31:0] flg);
    check_eq({tag, "_cfg"}, clk_gating_cfg, cfg);
    check_eq({tag, "_status"}, 32'(clk_on_status), st);
    check_eq({tag, "_flag"}, 32'(to_flag), flg);
    check_eq({tag, "_irq"}, 32'(to_irq), 32'(flg != 0));
  endtask

  logic [7:0] idle_pat;

  initial begin
    sys_rst     = 1'b1;
    sw_clk_en   = '1;
    wake_req    = '0;
    periph_idle = '1;
    to_clr      = '0;
    idle_pat    = 8'b1111_0111;  // bit k = idle sample k: 1,1,1,0,1,1,1,1

    // Reset
    tick(2);
    check_all("reset", 32'h0001FFFF, 32'h1FFFF, 0);
    sys_rst = 1'b0;
    tick(1);
    check_all("post_reset", 32'h0001FFFF, 32'h1FFFF, 0);

    // UART0 gating: cfg falls on the 5th edge
    sw_clk_en[0] = 1'b0;
    tick(4);
    check_all("uart0_drain", 32'h0001FFFF, 32'h1FFFF, 0);
    tick(1);
    check_all("uart0_off", 32'h0001FFFE, 32'h1FFFE, 0);

    // I2C2 idle run interrupted once
    sw_clk_en[8] = 1'b0;
    tick(1);
    for (int k = 0; k < 8; k++) begin
      periph_idle[8] = idle_pat[k];
      tick(1);
      if (k == 6) check_all("i2c2_drain7", 32'h0001FFFE, 32'h1FFFE, 0);
    end
    check_all("i2c2_off", 32'h0001FEFE, 32'h1FEFE, 0);
    periph_idle[8] = 1'b1;

    // WDT timeout, retry, clear, set-wins
    periph_idle[14] = 1'b0;
    sw_clk_en[14]   = 1'b0;
    tick(255);
    check_all("wdt_pre_to", 32'h0001FEFE, 32'h1FEFE, 0);
    tick(1);
    check_all("wdt_to1", 32'h0001FEFE, 32'h1FEFE, 32'h4000);
    to_clr[14] = 1'b1;
    tick(1);
    to_clr[14] = 1'b0;
    check_all("wdt_clr", 32'h0001FEFE, 32'h1FEFE, 0);
    tick(254);
    check_all("wdt_pre_to2", 32'h0001FEFE, 32'h1FEFE, 0);
    to_clr[14] = 1'b1;
    tick(1);
    to_clr[14] = 1'b0;
    check_all("wdt_set_wins", 32'h0001FEFE, 32'h1FEFE, 32'h4000);
    sw_clk_en[14]   = 1'b1;
    periph_idle[14] = 1'b1;
    tick(1);
    to_clr[14] = 1'b1;
    tick(1);
    to_clr[14] = 1'b0;
    check_all("wdt_clr2", 32'h0001FEFE, 32'h1FEFE, 0);

    // PWM: gate, one-cycle wake pulse, settle, re-gate
    sw_clk_en[16] = 1'b0;
    tick(5);
    check_all("pwm_off", 32'h0000FEFE, 32'h0FEFE, 0);
    wake_req[16] = 1'b1;
    tick(1);
    wake_req[16] = 1'b0;
    check_all("pwm_wake1", 32'h0001FEFE, 32'h0FEFE, 0);
    tick(1);
    check_all("pwm_wake2", 32'h0001FEFE, 32'h0FEFE, 0);
    tick(1);
    check_all("pwm_on", 32'h0001FEFE, 32'h1FEFE, 0);
    tick(4);
    check_all("pwm_redrain", 32'h0001FEFE, 32'h1FEFE, 0);
    tick(1);
    check_all("pwm_regate", 32'h0000FEFE, 32'h0FEFE, 0);

    // ADC abort mid-DRAIN
    sw_clk_en[15] = 1'b0;
    tick(3);
    check_all("adc_drain", 32'h0000FEFE, 32'h0FEFE, 0);
    sw_clk_en[15] = 1'b1;
    tick(1);
    check_all("adc_abort", 32'h0000FEFE, 32'h0FEFE, 0);
    tick(6);
    check_all("adc_stay_on", 32'h0000FEFE, 32'h0FEFE, 0);

    // Timer: gate, wake, reset mid-WAKE
    sw_clk_en[12] = 1'b0;
    tick(5);
    check_all("tmr_off", 32'h0000EEFE, 32'h0EEFE, 0);
    sw_clk_en[12] = 1'b1;
    tick(1);
    check_all("tmr_wake", 32'h0000FEFE, 32'h0EEFE, 0);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    check_all("tmr_rst", 32'h0001FFFF, 32'h1FFFF, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
